// File: rtl/audio_mix_sequencer.sv
// Time-multiplexed PCM mixer: snapshots all sources on a sample strobe, accumulates
// one attenuated source per cycle, then applies master attenuation and saturation.
module audio_mix_sequencer #(
    parameter int NUM_SRC = 4,
    parameter int PCM_W   = 14,
    parameter int OUT_W   = 16,
    parameter int ATT_W   = 4
) (
    input  logic                     clk_logic,
    input  logic                     system_reset_n,
    input  logic                     sample_strobe_i,
    input  logic [NUM_SRC*PCM_W-1:0] src_pcm_i,
    input  logic [NUM_SRC-1:0]       src_enable_i,
    input  logic [NUM_SRC*ATT_W-1:0] src_atten_i,
    input  logic [2:0]               master_atten_i,
    input  logic                     clear_overrun_i,
    output logic [OUT_W-1:0]         mix_o,
    output logic                     mix_valid_o,
    output logic                     clip_o,
    output logic                     busy_o,
    output logic                     overrun_o
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int ACC_W = PCM_W + $clog2(NUM_SRC) + 1;
    localparam int SC_W  = ACC_W + OUT_W - PCM_W;
    localparam int UP_SH = OUT_W - PCM_W;

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t                    state_q, state_d;
    logic signed [PCM_W-1:0]   pcm_q [NUM_SRC];
    logic [ATT_W-1:0]          att_q [NUM_SRC];
    logic [NUM_SRC-1:0]        en_q;
    logic [2:0]                master_q;
    logic signed [ACC_W-1:0]   acc_q, term;
    logic [IDX_W-1:0]          idx_q;
    logic signed [SC_W-1:0]    scaled;
    logic [SC_W-OUT_W:0]       scaled_hi;
    logic                      sat;
    logic [OUT_W-1:0]          mix_q, mix_d;
    logic                      mix_valid_q, clip_q, overrun_q;
    logic                      last_src, accept;

    assign last_src = (idx_q == IDX_W'(NUM_SRC - 1));
    assign accept   = sample_strobe_i && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_strobe_i) state_d = ACCUM;
            ACCUM:   if (last_src) state_d = OUTPUT;
            OUTPUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shifts are arithmetic throughout, so negative values round toward -inf.
    always_comb begin
        term = '0;
        if (en_q[idx_q]) term = ACC_W'(pcm_q[idx_q]) >>> att_q[idx_q];
        scaled    = (SC_W'(acc_q) <<< UP_SH) >>> master_q;
        scaled_hi = scaled[SC_W-1:OUT_W-1];
        sat       = !((&scaled_hi) || !(|scaled_hi));
        mix_d     = scaled[OUT_W-1:0];
        if (sat) mix_d = scaled[SC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q     <= IDLE;
            en_q        <= '0;
            master_q    <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < NUM_SRC; k++) begin
                pcm_q[k] <= '0;
                att_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mix_valid_q <= (state_q == OUTPUT);
            clip_q      <= (state_q == OUTPUT) && sat;
            if (accept) begin
                en_q     <= src_enable_i;
                master_q <= master_atten_i;
                acc_q    <= '0;
                idx_q    <= '0;
                for (int k = 0; k < NUM_SRC; k++) begin
                    pcm_q[k] <= src_pcm_i[k*PCM_W +: PCM_W];
                    att_q[k] <= src_atten_i[k*ATT_W +: ATT_W];
                end
            end
            if (state_q == ACCUM) begin
                acc_q <= acc_q + term;
                if (!last_src) idx_q <= idx_q + 1'b1;
            end
            if (state_q == OUTPUT) mix_q <= mix_d;
            // A strobe while busy beats a simultaneous clear.
            if (sample_strobe_i && (state_q != IDLE)) overrun_q <= 1'b1;
            else if (clear_overrun_i)                 overrun_q <= 1'b0;
        end
    end

    assign mix_o       = mix_q;
    assign mix_valid_o = mix_valid_q;
    assign clip_o      = clip_q;
    assign busy_o      = (state_q != IDLE);
    assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Directed bench for audio_mix_sequencer with hand-computed mix results.
module tb_audio_mix_sequencer;
    localparam int NUM_SRC = 4;
    localparam int PCM_W   = 14;
    localparam int OUT_W   = 16;
    localparam int ATT_W   = 4;

    logic                     clk_logic = 1'b0;
    logic                     system_reset_n;
    logic                     sample_strobe_i;
    logic [NUM_SRC*PCM_W-1:0] src_pcm_i;
    logic [NUM_SRC-1:0]       src_enable_i;
    logic [NUM_SRC*ATT_W-1:0] src_atten_i;
    logic [2:0]               master_atten_i;
    logic                     clear_overrun_i;
    logic [OUT_W-1:0]         mix_o;
    logic                     mix_valid_o;
    logic                     clip_o;
    logic                     busy_o;
    logic                     overrun_o;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0;
    int bad_clip  = 0;
    int v0;

    audio_mix_sequencer #(.NUM_SRC(NUM_SRC), .PCM_W(PCM_W), .OUT_W(OUT_W), .ATT_W(ATT_W)) dut (
        .clk_logic       (clk_logic),
        .system_reset_n  (system_reset_n),
        .sample_strobe_i (sample_strobe_i),
        .src_pcm_i       (src_pcm_i),
        .src_enable_i    (src_enable_i),
        .src_atten_i     (src_atten_i),
        .master_atten_i  (master_atten_i),
        .clear_overrun_i (clear_overrun_i),
        .mix_o           (mix_o),
        .mix_valid_o     (mix_valid_o),
        .clip_o          (clip_o),
        .busy_o          (busy_o),
        .overrun_o       (overrun_o)
    );

    always #5 clk_logic = ~clk_logic;

    always @(negedge clk_logic) begin
        if (mix_valid_o) valid_cnt++;
        if (!mix_valid_o && clip_o) bad_clip++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk_logic);
        #1;
    endtask

    task automatic set_src(input int p0, input int p1, input int p2, input int p3,
                           input logic [3:0] en, input logic [15:0] att, input logic [2:0] m);
        src_pcm_i      = {14'(p3), 14'(p2), 14'(p1), 14'(p0)};
        src_enable_i   = en;
        src_atten_i    = att;
        master_atten_i = m;
    endtask

    task automatic strobe();
        sample_strobe_i = 1'b1;
        tick();
        sample_strobe_i = 1'b0;
    endtask

    task automatic wait_mix(input string tag, input int exp_mix, input int exp_clip);
        int cyc = 0;
        int busy_n = 0;
        while (!mix_valid_o && cyc < 20) begin
            if (busy_o) busy_n++;
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, 5);
        check({tag, " busy"}, busy_n, 5);
        check({tag, " mix"}, int'($signed(mix_o)), exp_mix);
        check({tag, " clip"}, int'(clip_o), exp_clip);
        tick();
    endtask

    initial begin
        system_reset_n  = 1'b0;
        sample_strobe_i = 1'b0;
        clear_overrun_i = 1'b0;
        set_src(0, 0, 0, 0, 4'h0, 16'h0, 3'd0);
        repeat (3) tick();
        system_reset_n = 1'b1;
        tick();
        check("rst mix", int'(mix_o), 0);
        check("rst valid", int'(mix_valid_o), 0);
        check("rst clip", int'(clip_o), 0);
        check("rst busy", int'(busy_o), 0);
        check("rst overrun", int'(overrun_o), 0);

        set_src(-8192, 0, 0, 0, 4'b0001, 16'h0, 3'd0);
        strobe(); wait_mix("neg full", -32768, 0);
        set_src(8191, 8191, 8191, 8191, 4'hF, 16'h0, 3'd0);
        strobe(); wait_mix("pos clip", 32767, 1);
        set_src(8191, 8191, 8191, 8191, 4'hF, 16'h0, 3'd2);
        strobe(); wait_mix("master2", 32764, 0);
        set_src(1000, -3000, 8191, -8192, 4'hF, 16'hFD10, 3'd0);
        strobe(); wait_mix("atten mix", -2004, 0);
        set_src(-1, 0, 0, 0, 4'b0001, 16'h0, 3'd3);
        strobe(); wait_mix("neg round", -1, 0);
        set_src(100, 200, 300, 400, 4'b0101, 16'h0, 3'd0);
        strobe(); wait_mix("enables", 1600, 0);
        set_src(-8192, -8192, -8192, -8192, 4'hF, 16'h0, 3'd0);
        strobe(); wait_mix("neg clip", -32768, 1);

        set_src(500, 0, 0, 0, 4'b0001, 16'h0, 3'd0);
        strobe();
        set_src(8191, 8191, 8191, 8191, 4'hF, 16'h0, 3'd0);
        wait_mix("snapshot", 2000, 0);

        v0 = valid_cnt;
        set_src(10, 0, 0, 0, 4'b0001, 16'h0, 3'd0);
        strobe(); tick(); tick();
        sample_strobe_i = 1'b1;
        clear_overrun_i = 1'b1;
        tick();
        sample_strobe_i = 1'b0;
        clear_overrun_i = 1'b0;
        check("overrun set wins", int'(overrun_o), 1);
        repeat (8) tick();
        check("overrun one pulse", valid_cnt - v0, 1);
        check("overrun mix", int'($signed(mix_o)), 40);
        clear_overrun_i = 1'b1;
        tick();
        clear_overrun_i = 1'b0;
        check("overrun clear", int'(overrun_o), 0);

        v0 = valid_cnt;
        strobe();
        repeat (5) tick();
        set_src(20, 0, 0, 0, 4'b0001, 16'h0, 3'd0);
        strobe();
        repeat (8) tick();
        check("spacing6 pulses", valid_cnt - v0, 2);
        check("spacing6 mix", int'($signed(mix_o)), 80);
        check("spacing6 overrun", int'(overrun_o), 0);

        strobe();
        sample_strobe_i = 1'b1;
        tick();
        sample_strobe_i = 1'b0;
        system_reset_n = 1'b0;
        #1;
        check("midrst mix", int'(mix_o), 0);
        check("midrst busy", int'(busy_o), 0);
        check("midrst overrun", int'(overrun_o), 0);
        tick();
        system_reset_n = 1'b1;
        v0 = valid_cnt;
        repeat (10) tick();
        check("midrst no pulse", valid_cnt - v0, 0);
        check("midrst mix held", int'(mix_o), 0);
        set_src(-300, 0, 0, 0, 4'b0001, 16'h0, 3'd1);
        strobe(); wait_mix("after rst", -600, 0);

        check("clip outside valid", bad_clip, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
